// File: rtl/secret_vec_pkg.sv
// Shared constants, state/mode enums and the golden model for the secret_vec
// stimulus sequencer.
package secret_vec_pkg;

    localparam int MAX_VEC = 8;

    localparam logic [31:0] VEC_A [MAX_VEC] = '{
        32'd5, 32'd6, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0
    };
    localparam logic [31:0] VEC_B [MAX_VEC] = '{
        32'd7, 32'd2, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        EXP_ADD,
        EXP_XOR,
        EXP_AND,
        EXP_SUB
    } exp_mode_e;

    // All modes wrap at 32 bits.
    function automatic logic [31:0] golden(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input exp_mode_e   mode);
        logic [31:0] r;
        case (mode)
            EXP_ADD: r = a + b;
            EXP_XOR: r = a ^ b;
            EXP_AND: r = a & b;
            default: r = a - b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/secret_vec_cmp.sv
// Golden-model compare of the driven operands against x, plus a pair of
// saturating pass/fail counters that advance on each enabled compare.
module secret_vec_cmp
    import secret_vec_pkg::*;
#(
    parameter exp_mode_e MODE = EXP_ADD
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] x,
    output logic        match,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt
);

    logic [1:0] hit;
    logic [7:0] cnt_out [2];

    assign match = (x == golden(a, b, MODE));
    // Counter 0 tracks matches, counter 1 tracks mismatches.
    assign hit   = {~match, match};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_cnt
        logic [7:0] cnt_q;
        logic [7:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (en && hit[gi] && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_l) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_out[gi] = cnt_q;
    end

    assign pass_cnt = cnt_out[0];
    assign fail_cnt = cnt_out[1];

endmodule

// File: rtl/secret_vec_seq.sv
// Replays the package operand table onto a/b, waits LATENCY cycles, then checks
// x against the golden model and keeps pass/fail statistics.
module secret_vec_seq
    import secret_vec_pkg::*;
#(
    parameter int NUM_VEC  = 3,
    parameter int LATENCY  = 1,
    parameter int EXP_MODE = 0
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        start,
    input  logic [31:0] x,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic [3:0]  first_fail,
    output logic [31:0] last_x
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);
    localparam exp_mode_e  MODE     = exp_mode_e'(2'(EXP_MODE));

    seq_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic [31:0] last_x_q, last_x_d;

    logic        accept_start;
    logic        cnt_clr;
    logic        cmp_en;
    logic        match;

    assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign cnt_clr      = accept_start;
    assign cmp_en       = (state_q == ST_CHECK);

    secret_vec_cmp #(
        .MODE (MODE)
    ) u_cmp (
        .clk      (clk),
        .reset_l  (reset_l),
        .clr      (cnt_clr),
        .en       (cmp_en),
        .a        (a_q),
        .b        (b_q),
        .x        (x),
        .match    (match),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        a_d          = a_q;
        b_d          = b_q;
        first_fail_d = first_fail_q;
        last_x_d     = last_x_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    idx_d        = '0;
                    wait_d       = '0;
                    first_fail_d = '0;
                end
            end
            ST_DRIVE: begin
                a_d     = VEC_A[idx_q];
                b_d     = VEC_B[idx_q];
                wait_d  = LAT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) begin
                    wait_d  = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                last_x_d = x;
                if (!match && !first_fail_q[3]) begin
                    first_fail_d = {1'b1, idx_q};
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wait_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            first_fail_q <= '0;
            last_x_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            first_fail_q <= first_fail_d;
            last_x_q     <= last_x_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign first_fail = first_fail_q;
    assign last_x     = last_x_q;

endmodule

// File: tb/tb_secret_vec_seq.sv
// Scoreboard bench for secret_vec_seq: several parameterisations, each with its
// own delayed x model standing in for the downstream secret block.
module tb_secret_vec_seq;

    localparam int NDUT = 6;

    function automatic int lat_of(input int i);
        return (i == 4) ? 4 : 1;
    endfunction
    function automatic int nv_of(input int i);
        return (i == 5) ? 8 : 3;
    endfunction
    function automatic int mode_of(input int i);
        return (i < 4) ? i : 0;
    endfunction
    function automatic logic [31:0] tb_gold(input int mode, input logic [31:0] a, input logic [31:0] b);
        case (mode)
            0:       return a + b;
            1:       return a ^ b;
            2:       return a & b;
            default: return a - b;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        start      [NDUT];
    logic [31:0] x          [NDUT];
    logic [31:0] a          [NDUT];
    logic [31:0] b          [NDUT];
    logic        busy       [NDUT];
    logic        done       [NDUT];
    logic [7:0]  pass_cnt   [NDUT];
    logic [7:0]  fail_cnt   [NDUT];
    logic [3:0]  first_fail [NDUT];
    logic [31:0] last_x     [NDUT];

    int          dly_v   [NDUT] = '{default: 1};
    bit          inj_v   [NDUT] = '{default: 1'b0};
    bit          stuck_v [NDUT] = '{default: 1'b0};
    logic [31:0] prev_a  [NDUT] = '{default: 32'd0};
    logic [31:0] prev_b  [NDUT] = '{default: 32'd0};

    logic [31:0] tb_a [8] = '{32'd5, 32'd6, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] tb_b [8] = '{32'd7, 32'd2, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    typedef struct {
        int          pass_n;
        int          fail_n;
        logic [3:0]  ff;
        logic [31:0] lx;
        int          cyc;
    } res_t;

    res_t        res_q [$];
    logic [63:0] vec_q [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
        logic [31:0] pipe [8];

        secret_vec_seq #(
            .NUM_VEC  (nv_of(gi)),
            .LATENCY  (lat_of(gi)),
            .EXP_MODE (mode_of(gi))
        ) u_dut (
            .clk        (clk),
            .reset_l    (reset_l),
            .start      (start[gi]),
            .x          (x[gi]),
            .a          (a[gi]),
            .b          (b[gi]),
            .busy       (busy[gi]),
            .done       (done[gi]),
            .pass_cnt   (pass_cnt[gi]),
            .fail_cnt   (fail_cnt[gi]),
            .first_fail (first_fail[gi]),
            .last_x     (last_x[gi])
        );

        // x model: golden of a/b, optionally +1 on the (6,2) vector, delayed dly_v cycles.
        always @(posedge clk) begin
            pipe[0] <= tb_gold(mode_of(gi), a[gi], b[gi])
                       + ((inj_v[gi] && a[gi] == 32'd6 && b[gi] == 32'd2) ? 32'd1 : 32'd0);
            for (int j = 1; j < 8; j++) pipe[j] <= pipe[j-1];
        end
        assign x[gi] = stuck_v[gi] ? 32'd0 : pipe[dly_v[gi] - 1];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input int id, input string tag);
        chk({tag, "_a"},    a[id], 0);
        chk({tag, "_b"},    b[id], 0);
        chk({tag, "_flags"}, {busy[id], done[id], first_fail[id]}, 0);
        chk({tag, "_cnts"}, {pass_cnt[id], fail_cnt[id]}, 0);
        chk({tag, "_lastx"}, last_x[id], 0);
    endtask

    task automatic run(input int id, input int dly, input bit inj, input bit spam);
        int          lat, nv, mode, n, pc, fc;
        logic [3:0]  ff;
        logic [31:0] sa, sb, xv, ev;
        logic [63:0] ab;
        res_t        r;
        lat = lat_of(id);
        nv  = nv_of(id);
        mode = mode_of(id);
        dly_v[id] = dly;
        inj_v[id] = inj;
        pc = 0; fc = 0; ff = '0; xv = '0;
        for (int k = 0; k < nv; k++) begin
            vec_q.push_back({tb_a[k], tb_b[k]});
            // Too-long a delay makes each check see the previous vector's result.
            sa = (dly <= lat) ? tb_a[k] : ((k == 0) ? prev_a[id] : tb_a[k-1]);
            sb = (dly <= lat) ? tb_b[k] : ((k == 0) ? prev_b[id] : tb_b[k-1]);
            xv = tb_gold(mode, sa, sb) + ((inj && sa == 32'd6 && sb == 32'd2) ? 32'd1 : 32'd0);
            ev = tb_gold(mode, tb_a[k], tb_b[k]);
            if (xv == ev) begin
                if (pc < 255) pc++;
            end else begin
                if (fc < 255) fc++;
                if (!ff[3]) ff = {1'b1, 3'(k)};
            end
        end
        r = '{pc, fc, ff, xv, nv * (lat + 2)};
        res_q.push_back(r);

        @(negedge clk) start[id] = 1'b1;
        @(negedge clk) start[id] = spam;
        n = 0;
        chk("busy_on", busy[id], 1);
        chk("done_clr", {done[id], pass_cnt[id], fail_cnt[id], first_fail[id]}, 0);
        while (!done[id] && n < 400) begin
            @(negedge clk);
            n++;
            start[id] = spam && (n <= 2);
            if (((n - 1) % (lat + 2)) == 0 && vec_q.size() > 0) begin
                ab = vec_q.pop_front();
                chk("ab", {a[id], b[id]}, ab);
            end
        end
        start[id] = 1'b0;
        vec_q.delete();
        r = res_q.pop_front();
        chk("done_cyc", n, r.cyc);
        chk("busy_off", busy[id], 0);
        chk("pass_cnt", pass_cnt[id], r.pass_n);
        chk("fail_cnt", fail_cnt[id], r.fail_n);
        chk("first_fail", first_fail[id], r.ff);
        chk("last_x", last_x[id], r.lx);
        repeat (3) @(negedge clk);
        chk("done_hold", done[id], 1);
        chk("ab_hold", {a[id], b[id]}, {tb_a[nv-1], tb_b[nv-1]});
        prev_a[id] = tb_a[nv-1];
        prev_b[id] = tb_b[nv-1];
        $display("run dut=%0d dly=%0d inj=%0d spam=%0d cycles=%0d pass=%0d fail=%0d ff=%0h last_x=%0h",
                 id, dly, inj, spam, n, pass_cnt[id], fail_cnt[id], first_fail[id], last_x[id]);
    endtask

    task automatic reset_mid(input int id);
        @(negedge clk) start[id] = 1'b1;
        @(negedge clk) start[id] = 1'b0;
        repeat (4) @(negedge clk);
        reset_l = 1'b0;
        @(negedge clk);
        chk_reset_vals(id, "midrst");
        reset_l = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            prev_a[i] = '0;
            prev_b[i] = '0;
        end
        $display("reset mid-run dut=%0d a=%0h busy=%0d last_x=%0h", id, a[id], busy[id], last_x[id]);
    endtask

    initial begin
        int pc, fc;
        for (int i = 0; i < NDUT; i++) start[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) chk_reset_vals(i, "rst");
        reset_l = 1'b1;

        run(0, 1, 1'b0, 1'b0);
        run(0, 1, 1'b1, 1'b0);
        run(0, 1, 1'b0, 1'b0);
        run(0, 1, 1'b0, 1'b1);
        run(4, 4, 1'b0, 1'b0);
        run(4, 5, 1'b0, 1'b0);
        run(1, 1, 1'b0, 1'b0);
        run(2, 1, 1'b0, 1'b0);
        run(3, 1, 1'b0, 1'b0);
        reset_mid(0);
        run(0, 1, 1'b0, 1'b0);

        // Hold the counter clear off so statistics accumulate across runs.
        stuck_v[5] = 1'b1;
        force g_dut[5].u_dut.cnt_clr = 1'b0;
        pc = 0;
        fc = 0;
        for (int r = 0; r < 100; r++) begin
            int w;
            @(negedge clk) start[5] = 1'b1;
            @(negedge clk) start[5] = 1'b0;
            w = 0;
            while (!done[5] && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk("sat_done", done[5], 1);
            pc = (pc + 5 > 255) ? 255 : pc + 5;
            fc = (fc + 3 > 255) ? 255 : fc + 3;
            if (r == 79) begin
                chk("sat_mid_pass", pass_cnt[5], pc);
                chk("sat_mid_fail", fail_cnt[5], fc);
            end
        end
        chk("sat_pass", pass_cnt[5], pc);
        chk("sat_fail", fail_cnt[5], fc);
        $display("saturation dut=5 pass=%0d fail=%0d", pass_cnt[5], fail_cnt[5]);
        release g_dut[5].u_dut.cnt_clr;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
